// File: rtl/adder_8bit_serial_if.sv
// Handshake bundle for the bit-serial adder: operand request and result response.
interface adder_8bit_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  // Requester side: drives operands and result acceptance.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/adder_8bit_serial.sv
// Bit-serial two's-complement adder: one full-adder cell, LSB first,
// WIDTH cycles per operation, valid/ready on both sides.
module adder_8bit_serial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_8bit_serial_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             c, a_msb, b_msb;
  logic             s, c_nxt, last, accept;

  // Full-adder cell on the current LSBs plus running carry.
  always_comb begin
    s      = a_sh[0] ^ b_sh[0] ^ c;
    c_nxt  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    last   = (cnt == LAST);
    accept = bus.in_valid && (state == IDLE);
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath; visible result/flags only move on the final RUN cycle,
  // so the partial sum in r_sh never leaks out mid-operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh          <= '0;
      b_sh          <= '0;
      r_sh          <= '0;
      c             <= 1'b0;
      cnt           <= '0;
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      c     <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= {s, r_sh[WIDTH-1:1]};
      c    <= c_nxt;
      if (last) begin
        cnt           <= '0;
        bus.result    <= {s, r_sh[WIDTH-1:1]};
        bus.carry_out <= c_nxt;
        bus.overflow  <= (a_msb == b_msb) && (s != a_msb);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
